multdiv_sequencer: RTL and testbench

MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

---
 rtl/multdiv_sequencer.sv | 156 +++++++++++++++
 tb/tb_multdiv_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_sequencer.sv
// Sequential signed multiply / divide unit.
// Multiply: radix-2 Booth, one recoded bit per cycle.
// Divide: non-restoring on operand magnitudes, sign fixed up at the end.
// Timing: after the start edge there are WIDTH iteration cycles, then one
// finalize cycle. DONE is therefore entered WIDTH+1 edges after the start edge.
// Handshake: ctrl_MULT/ctrl_DIV are sampled only in IDLE or DONE and are
// ignored in any other state. data_resultRDY is high for exactly the one
// cycle spent in DONE. data_result and data_exception then hold until the
// next DONE entry.
module multdiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic [1:0]       o_dbg_state
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MULT = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;      // iteration index 0..WIDTH-1, saturates
   logic             r_fin;      // all iterations done; next edge finalizes
   logic [WIDTH:0]   r_acc;      // mult: upper product half (sign-extended); div: partial remainder
   logic [WIDTH-1:0] r_lo;       // mult: lower product half / multiplier; div: quotient / dividend bits
   logic             r_q1;       // Booth q(-1) bit
   logic [WIDTH-1:0] r_opnd;     // mult: multiplicand; div: divisor magnitude
   logic             r_neg;      // div: quotient must be negated
   logic             r_dz;       // div: divisor was zero
   logic [WIDTH-1:0] r_result;
   logic             r_exc;
   logic             r_rdy;

   logic [WIDTH:0]   w_m_ext;
   logic [WIDTH:0]   w_booth_sum;
   logic [WIDTH:0]   w_div_shift;
   logic [WIDTH:0]   w_d_ext;
   logic [WIDTH:0]   w_div_rem;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic [WIDTH-1:0] w_quot;
   logic             w_mult_exc;
   logic             w_last_iter;

   assign w_m_ext     = {r_opnd[WIDTH-1], r_opnd};
   assign w_d_ext     = {1'b0, r_opnd};
   assign w_div_shift = {r_acc[WIDTH-1:0], r_lo[WIDTH-1]};
   assign w_div_rem   = r_acc[WIDTH] ? (w_div_shift + w_d_ext) : (w_div_shift - w_d_ext);
   assign w_abs_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
   assign w_abs_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
   assign w_quot      = r_neg ? -r_lo : r_lo;
   assign w_mult_exc  = (r_acc[WIDTH-1:0] != {WIDTH{r_lo[WIDTH-1]}});
   assign w_last_iter = (r_cnt == CW'(WIDTH - 1));

   // Booth step: pick add, subtract or skip of the multiplicand from {q0, q-1}.
   always_comb begin
      w_booth_sum = r_acc;
      case ({r_lo[0], r_q1})
         2'b01:   w_booth_sum = r_acc + w_m_ext;
         2'b10:   w_booth_sum = r_acc - w_m_ext;
         default: w_booth_sum = r_acc;
      endcase
   end

   // Control FSM and datapath registers, with the outputs registered here.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_fin    <= 1'b0;
         r_acc    <= '0;
         r_lo     <= '0;
         r_q1     <= 1'b0;
         r_opnd   <= '0;
         r_neg    <= 1'b0;
         r_dz     <= 1'b0;
         r_result <= '0;
         r_exc    <= 1'b0;
         r_rdy    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               r_rdy <= 1'b0;
               r_cnt <= '0;
               r_fin <= 1'b0;
               if (ctrl_MULT) begin
                  // Multiply has priority over divide when both are requested.
                  r_state <= S_MULT;
                  r_acc   <= '0;
                  r_lo    <= data_operandB;
                  r_q1    <= 1'b0;
                  r_opnd  <= data_operandA;
               end else if (ctrl_DIV) begin
                  r_state <= S_DIV;
                  r_acc   <= '0;
                  r_lo    <= w_abs_a;
                  r_opnd  <= w_abs_b;
                  r_neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                  r_dz    <= (data_operandB == '0);
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_MULT: begin
               if (r_fin) begin
                  r_state  <= S_DONE;
                  r_rdy    <= 1'b1;
                  r_result <= r_lo;
                  r_exc    <= w_mult_exc;
               end else begin
                  // Arithmetic shift right of {acc, lo, q-1} by one.
                  r_acc <= {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
                  r_lo  <= {w_booth_sum[0], r_lo[WIDTH-1:1]};
                  r_q1  <= r_lo[0];
                  if (w_last_iter) r_fin <= 1'b1;
                  else             r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DIV: begin
               if (r_fin) begin
                  r_state  <= S_DONE;
                  r_rdy    <= 1'b1;
                  r_result <= r_dz ? '0 : w_quot;
                  r_exc    <= r_dz;
               end else begin
                  // Shift in next dividend bit; quotient bit is 1 when remainder stays non-negative.
                  r_acc <= w_div_rem;
                  r_lo  <= {r_lo[WIDTH-2:0], ~w_div_rem[WIDTH]};
                  if (w_last_iter) r_fin <= 1'b1;
                  else             r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign data_result    = r_result;
   assign data_exception = r_exc;
   assign data_resultRDY = r_rdy;
   assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for multdiv_sequencer: table of directed vectors, random vectors from
// a reference model, and hand-written sequences for the abort, restart and
// ignored-start cases.
module tb_multdiv_sequencer;

   localparam int W = 32;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         ctrl_MULT = 1'b0;
   logic         ctrl_DIV = 1'b0;
   logic [W-1:0] data_operandA = '0;
   logic [W-1:0] data_operandB = '0;
   logic [W-1:0] data_result;
   logic         data_exception;
   logic         data_resultRDY;
   logic [1:0]   o_dbg_state;

   multdiv_sequencer #(.WIDTH(W)) dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .o_dbg_state    (o_dbg_state)
   );

   // Clock
   always #5 clock = ~clock;

   typedef struct {
      logic         m;
      logic         d;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         exc;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   logic [W:0] exp_q[$];
   logic [W:0] mon_e;
   int n_checks = 0;
   int n_fail = 0;
   int rdy_seen = 0;
   int rdy_expected = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: {exception, result}
   function automatic logic [W:0] model(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [63:0] p;
      logic [W-1:0] q;
      if (m) begin
         p = $signed({{32{a[W-1]}}, a}) * $signed({{32{b[W-1]}}, b});
         return {(p[63:32] != {32{p[31]}}), p[31:0]};
      end
      if (b == '0) return {1'b1, 32'h0};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      return {1'b0, q};
   endfunction

   // Scoreboard: every RDY pulse pops and compares one expected result
   always @(negedge clock) begin
      if (reset && data_resultRDY) begin
         rdy_seen++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rdy: got result 0x%0h with empty queue, expected no pulse", data_result);
         end else begin
            mon_e = exp_q.pop_front();
            check("result", {32'h0, data_result}, {32'h0, mon_e[W-1:0]});
            check("exception", {63'h0, data_exception}, {63'h0, mon_e[W]});
         end
      end
   end

   // Drive a start request (call at a negedge)
   task automatic start_op(input logic m, input logic d, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic push, input logic [W:0] e);
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      data_operandA = a;
      data_operandB = b;
      if (push) begin
         exp_q.push_back(e);
         rdy_expected++;
      end
   endtask

   // Follow an operation from its start edge to the RDY cycle, scrambling
   // operands each cycle; optionally inject stray start requests mid-run.
   task automatic wait_rdy(input string name, input logic disturb);
      int lat;
      lat = 0;
      @(posedge clock);
      @(negedge clock);
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clock);
         @(negedge clock);
         if (data_resultRDY) begin
            lat = k;
            break;
         end
         data_operandA = $urandom;
         data_operandB = $urandom;
         ctrl_DIV  = disturb && (k == 10);
         ctrl_MULT = disturb && (k == 20);
      end
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      check({name, "_latency"}, 64'(lat), 64'd33);
   endtask

   // After the DONE cycle: RDY must drop and the FSM returns to IDLE
   task automatic after_done(input string name);
      @(posedge clock);
      @(negedge clock);
      check({name, "_rdy_drop"}, {63'h0, data_resultRDY}, 64'h0);
      check({name, "_idle"}, {62'h0, o_dbg_state}, 64'h0);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
      vecs[2]  = '{1'b1, 1'b0, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 32'd100,       32'd0,         32'h0000_0000, 1'b1};
      vecs[5]  = '{1'b1, 1'b1, 32'd6,         32'd3,         32'd18,        1'b0};
      vecs[6]  = '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 32'd9,         32'd3,         32'd3,         1'b0};
      vecs[8]  = '{1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        1'b0};
      vecs[9]  = '{1'b0, 1'b1, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 32'd5,         32'd7,         32'd0,         1'b0};
      vecs[11] = '{1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
      vecs[12] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1'b0};
      vecs[13] = '{1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2,         32'hFFFF_FFFE, 1'b1};
      vecs[14] = '{1'b0, 1'b1, 32'h8000_0000, 32'd2,         32'hC000_0000, 1'b0};
      vecs[15] = '{1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};

      // Reset state, applied asynchronously
      #2 reset = 1'b0;
      #1;
      check("reset_result", {32'h0, data_result}, 64'h0);
      check("reset_exception", {63'h0, data_exception}, 64'h0);
      check("reset_rdy", {63'h0, data_resultRDY}, 64'h0);
      check("reset_state", {62'h0, o_dbg_state}, 64'h0);
      repeat (2) @(negedge clock);
      reset = 1'b1;

      // Directed table; first start goes in on the first edge after release
      for (int i = 0; i < NV; i++) begin
         start_op(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b, 1'b1, {vecs[i].exc, vecs[i].res});
         wait_rdy($sformatf("vec%0d", i), 1'b0);
         after_done($sformatf("vec%0d", i));
      end

      // Random vectors against the reference model
      for (int i = 0; i < 8; i++) begin
         logic m;
         logic [W-1:0] a, b;
         m = i[0];
         a = $urandom;
         b = m ? {{16{1'b0}}, 16'($urandom_range(0, 65535))} : 32'($urandom_range(1, 5000));
         if ($urandom_range(0, 1) == 1) b = -b;
         if (i == 6) a = 32'd0;
         start_op(m, ~m, a, b, 1'b1, model(m, a, b));
         wait_rdy($sformatf("rnd%0d", i), 1'b0);
         after_done($sformatf("rnd%0d", i));
      end

      // Stray starts and operand changes mid-multiply are ignored
      start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 1'b1, {1'b0, 32'hFFFF_FFD6});
      wait_rdy("ignore_start", 1'b1);
      after_done("ignore_start");

      // Both requests: multiply wins; restart during DONE gives full latency again
      start_op(1'b1, 1'b1, 32'd6, 32'd3, 1'b1, {1'b0, 32'd18});
      wait_rdy("both_req", 1'b0);
      start_op(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 1'b1, {1'b0, 32'hFFFF_FFF2});
      wait_rdy("restart_in_done", 1'b0);
      after_done("restart_in_done");

      // Leave nonzero outputs, then abort a divide with reset at cycle 20
      start_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2, 1'b1, {1'b1, 32'hFFFF_FFFE});
      wait_rdy("pre_abort", 1'b0);
      after_done("pre_abort");
      start_op(1'b0, 1'b1, 32'd1000, 32'd7, 1'b0, '0);
      @(posedge clock);
      @(negedge clock);
      ctrl_DIV = 1'b0;
      repeat (20) @(posedge clock);
      #2 reset = 1'b0;
      #1;
      check("abort_result", {32'h0, data_result}, 64'h0);
      check("abort_exception", {63'h0, data_exception}, 64'h0);
      check("abort_rdy", {63'h0, data_resultRDY}, 64'h0);
      check("abort_state", {62'h0, o_dbg_state}, 64'h0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      start_op(1'b0, 1'b1, 32'd9, 32'd3, 1'b1, {1'b0, 32'd3});
      wait_rdy("post_abort", 1'b0);
      after_done("post_abort");

      // Quiet period: any spurious pulse is caught by the scoreboard
      repeat (40) @(negedge clock);
      check("queue_empty", 64'(exp_q.size()), 64'h0);
      check("rdy_pulse_count", 64'(rdy_seen), 64'(rdy_expected));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
